// File: rtl/traffic_pkg.sv
// Shared state/phase encoding and constant helpers for the traffic controller.
package traffic_pkg;

    localparam logic [2:0] PH_ALLRED = 3'd0;
    localparam logic [2:0] PH_GREEN  = 3'd1;
    localparam logic [2:0] PH_YELLOW = 3'd2;
    localparam logic [2:0] PH_WALK   = 3'd3;
    localparam logic [2:0] PH_FLASH  = 3'd4;

    typedef enum logic [2:0] {
        ST_ALLRED = PH_ALLRED,
        ST_GREEN  = PH_GREEN,
        ST_YELLOW = PH_YELLOW,
        ST_WALK   = PH_WALK,
        ST_FLASH  = PH_FLASH
    } state_t;

    // Longest phase duration; sizes the shared phase timer.
    function automatic int max_dur(input int a, input int b, input int c,
                                   input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/traffic_ctrl_n_phase_tmr.sv
// Loadable phase down-counter; holds at zero and flags it for the controller.
module phase_tmr #(
    parameter int W       = 6,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= W'(RST_VAL);
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/traffic_ctrl_n.sv
// Round-robin traffic controller with pedestrian phase after every road cycle.
// Define PED_REQ_EN to run the pedestrian phase only when a request is pending.
module traffic_ctrl_n
    import traffic_pkg::*;
#(
    parameter int NUM_ROADS = 2,
    parameter int GREEN_T   = 40,
    parameter int YELLOW_T  = 5,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 25,
    parameter int FLASH_T   = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ped_req,
    output logic [NUM_ROADS-1:0]         road_g,
    output logic [NUM_ROADS-1:0]         road_y,
    output logic [NUM_ROADS-1:0]         road_r,
    output logic                         walk_g,
    output logic                         walk_r,
    output logic [2:0]                   phase,
    output logic [$clog2(NUM_ROADS)-1:0] cur_road
);

    localparam int RW    = $clog2(NUM_ROADS);
    localparam int MAX_T = max_dur(GREEN_T, YELLOW_T, ALLRED_T, WALK_T, FLASH_T);
    localparam int TW    = $clog2(MAX_T + 1);
    localparam logic [RW-1:0] LAST_ROAD = RW'(NUM_ROADS - 1);

    state_t                r_state;
    state_t                w_nxt_state;
    logic [RW-1:0]         r_road;
    logic [RW-1:0]         w_nxt_road;
    logic                  r_wrap;
    logic                  w_nxt_wrap;
    logic                  w_walk_due;
    logic                  w_tmr_zero;
    logic [TW-1:0]         w_load_val;
    logic [NUM_ROADS-1:0]  w_road_oh;
    logic [NUM_ROADS-1:0]  r_road_g;
    logic [NUM_ROADS-1:0]  r_road_y;
    logic [NUM_ROADS-1:0]  r_road_r;
    logic                  r_walk_g;
    logic                  r_walk_r;

    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_road  = r_road;
        w_nxt_wrap  = r_wrap;
        case (r_state)
            ST_ALLRED: begin
                w_nxt_wrap  = 1'b0;
                w_nxt_state = (r_wrap && w_walk_due) ? ST_WALK : ST_GREEN;
            end
            ST_GREEN:  w_nxt_state = ST_YELLOW;
            ST_YELLOW: begin
                w_nxt_state = ST_ALLRED;
                if (r_road == LAST_ROAD) begin
                    w_nxt_road = '0;
                    w_nxt_wrap = 1'b1;
                end else begin
                    w_nxt_road = r_road + 1'b1;
                end
            end
            ST_WALK:   w_nxt_state = ST_FLASH;
            ST_FLASH:  w_nxt_state = ST_ALLRED;
            default:   w_nxt_state = ST_ALLRED;
        endcase
    end

    always_comb begin
        case (w_nxt_state)
            ST_GREEN:  w_load_val = TW'(GREEN_T - 1);
            ST_YELLOW: w_load_val = TW'(YELLOW_T - 1);
            ST_WALK:   w_load_val = TW'(WALK_T - 1);
            ST_FLASH:  w_load_val = TW'(FLASH_T - 1);
            default:   w_load_val = TW'(ALLRED_T - 1);
        endcase
    end

    assign w_road_oh = NUM_ROADS'(1) << w_nxt_road;

    phase_tmr #(
        .W       (TW),
        .RST_VAL (ALLRED_T - 1)
    ) u_phase_tmr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_zero),
        .i_load_val (w_load_val),
        .o_zero     (w_tmr_zero)
    );

    // Lamps are registered from the state being entered, so they change with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_ALLRED;
            r_road   <= '0;
            r_wrap   <= 1'b0;
            r_road_g <= '0;
            r_road_y <= '0;
            r_road_r <= '1;
            r_walk_g <= 1'b0;
            r_walk_r <= 1'b1;
        end else if (w_tmr_zero) begin
            r_state  <= w_nxt_state;
            r_road   <= w_nxt_road;
            r_wrap   <= w_nxt_wrap;
            r_road_g <= (w_nxt_state == ST_GREEN)  ? w_road_oh : '0;
            r_road_y <= (w_nxt_state == ST_YELLOW) ? w_road_oh : '0;
            r_road_r <= (w_nxt_state inside {ST_GREEN, ST_YELLOW}) ? ~w_road_oh : '1;
            r_walk_g <= (w_nxt_state inside {ST_WALK, ST_FLASH});
            r_walk_r <= !(w_nxt_state inside {ST_WALK, ST_FLASH});
        end else if (r_state == ST_FLASH) begin
            r_walk_g <= ~r_walk_g;
        end
    end

`ifdef PED_REQ_EN
    logic r_ped_pend;

    // Clearing on WALK entry wins over a coincident request, consuming it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ped_pend <= 1'b0;
        end else if (w_tmr_zero && (w_nxt_state == ST_WALK)) begin
            r_ped_pend <= 1'b0;
        end else if (ped_req && (r_state != ST_WALK) && (r_state != ST_FLASH)) begin
            r_ped_pend <= 1'b1;
        end
    end

    assign w_walk_due = r_ped_pend;
`else
    logic w_unused_ped_req;
    assign w_unused_ped_req = ped_req;
    assign w_walk_due       = 1'b1;
`endif

    assign road_g   = r_road_g;
    assign road_y   = r_road_y;
    assign road_r   = r_road_r;
    assign walk_g   = r_walk_g;
    assign walk_r   = r_walk_r;
    assign phase    = r_state;
    assign cur_road = r_road;

endmodule
